// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci/Galois LFSR with runtime seed load,
// step enable, all-zero lock-up recovery and period-length measurement.
module lfsr_gen #(
  parameter int               WIDTH = 4,
  parameter int               MODE  = 0,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(4'b1100),
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(4'b1001),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(4'b0001),
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             enable,
  output logic [WIDTH-1:0] q,
  output logic             bit_out,
  output logic             lockup,
  output logic             period_done,
  output logic [CNT_W-1:0] period_len
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] plen_q, plen_d;
  logic             lock_q, lock_d;
  logic             pd_q, pd_d;

  logic [WIDTH-1:0] step_nxt;
  logic [CNT_W-1:0] cnt_inc;

  // One LFSR step from the current state, in the selected form.
  always_comb begin
    if (MODE == 0) begin
      step_nxt = {q_q[WIDTH-2:0], ^(q_q & TAPS)};
    end else begin
      step_nxt = {q_q[WIDTH-2:0], 1'b0} ^ (q_q[WIDTH-1] ? POLY : '0);
    end
  end

  // Step counter increment, saturating so a very long period never wraps.
  always_comb begin
    cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
  end

  // Next-state selection: load beats enable, enable beats hold.
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch;
    // the pulse defaults of 0 are also what makes them single-cycle.
    q_d     = q_q;
    start_d = start_q;
    cnt_d   = cnt_q;
    plen_d  = plen_q;
    lock_d  = 1'b0;
    pd_d    = 1'b0;
    if (load) begin
      cnt_d = '0;
      if (seed_in != '0) begin
        q_d     = seed_in;
        start_d = seed_in;
      end else begin
        q_d     = SEED;
        start_d = SEED;
        lock_d  = 1'b1;
      end
    end else if (enable) begin
      if (q_q == '0) begin
        // A zero state would stick forever; restart from the safe seed.
        q_d     = SEED;
        start_d = SEED;
        cnt_d   = '0;
        lock_d  = 1'b1;
      end else begin
        q_d = step_nxt;
        if (step_nxt == start_q) begin
          pd_d   = 1'b1;
          plen_d = cnt_inc;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    end
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      q_q     <= SEED;
      start_q <= SEED;
      cnt_q   <= '0;
      plen_q  <= '0;
      lock_q  <= 1'b0;
      pd_q    <= 1'b0;
    end else begin
      q_q     <= q_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
      plen_q  <= plen_d;
      lock_q  <= lock_d;
      pd_q    <= pd_d;
    end
  end

  assign q           = q_q;
  assign bit_out     = q_q[WIDTH-1];
  assign lockup      = lock_q;
  assign period_done = pd_q;
  assign period_len  = plen_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed + randomized check of lfsr_gen against a behavioural
// model. Four instances share stimulus: Fibonacci, Galois, an all-zero-prone
// mask (TAPS=0) and a rotation (TAPS=1000) with a 2-bit saturating counter.
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic       enable;
  logic [3:0] seed_in;

  logic [3:0]  dq    [4];
  logic        dbit  [4];
  logic        dlock [4];
  logic        dpd   [4];
  logic [15:0] dplen [3];
  logic [1:0]  plen_rot;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state, one entry per instance.
  logic [3:0] m_q     [4];
  logic [3:0] m_start [4];
  int         m_cnt   [4];
  int         m_plen  [4];
  logic       m_lock  [4];
  logic       m_pd    [4];

  int         c_mode [4] = '{0, 1, 0, 0};
  logic [3:0] c_taps [4] = '{4'hC, 4'hC, 4'h0, 4'h8};
  int         c_max  [4] = '{65535, 65535, 65535, 3};

  logic [3:0] fib_seq [15] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                               4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
  logic [3:0] gal_seq [15] = '{4'h2, 4'h4, 4'h8, 4'h9, 4'hB, 4'hF, 4'h7, 4'hE,
                               4'h5, 4'hA, 4'hD, 4'h3, 4'h6, 4'hC, 4'h1};

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(4), .MODE(0), .TAPS(4'b1100), .POLY(4'b1001), .SEED(4'b0001), .CNT_W(16)) u_fib (
    .clk(clk), .reset(reset), .load(load), .seed_in(seed_in), .enable(enable),
    .q(dq[0]), .bit_out(dbit[0]), .lockup(dlock[0]), .period_done(dpd[0]), .period_len(dplen[0]));

  lfsr_gen #(.WIDTH(4), .MODE(1), .TAPS(4'b1100), .POLY(4'b1001), .SEED(4'b0001), .CNT_W(16)) u_gal (
    .clk(clk), .reset(reset), .load(load), .seed_in(seed_in), .enable(enable),
    .q(dq[1]), .bit_out(dbit[1]), .lockup(dlock[1]), .period_done(dpd[1]), .period_len(dplen[1]));

  lfsr_gen #(.WIDTH(4), .MODE(0), .TAPS(4'b0000), .POLY(4'b1001), .SEED(4'b0001), .CNT_W(16)) u_zero (
    .clk(clk), .reset(reset), .load(load), .seed_in(seed_in), .enable(enable),
    .q(dq[2]), .bit_out(dbit[2]), .lockup(dlock[2]), .period_done(dpd[2]), .period_len(dplen[2]));

  lfsr_gen #(.WIDTH(4), .MODE(0), .TAPS(4'b1000), .POLY(4'b1001), .SEED(4'b0001), .CNT_W(2)) u_rot (
    .clk(clk), .reset(reset), .load(load), .seed_in(seed_in), .enable(enable),
    .q(dq[3]), .bit_out(dbit[3]), .lockup(dlock[3]), .period_done(dpd[3]), .period_len(plen_rot));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_plen(input int k);
    return (k == 3) ? {30'd0, plen_rot} : {16'd0, dplen[k]};
  endfunction

  // Spec step rule expressed arithmetically.
  function automatic logic [3:0] ref_next(input int k, input logic [3:0] s);
    logic [3:0] shifted;
    shifted = 4'((s << 1) & 4'hF);
    if (c_mode[k] == 0) return shifted | 4'($countones(s & c_taps[k]) % 2);
    else                return shifted ^ (s[3] ? 4'h9 : 4'h0);
  endfunction

  function automatic int sat_inc(input int k, input int v);
    return (v >= c_max[k]) ? c_max[k] : v + 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_q[k] = 4'h1; m_start[k] = 4'h1; m_cnt[k] = 0; m_plen[k] = 0;
      m_lock[k] = 1'b0; m_pd[k] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic l, input logic [3:0] s, input logic e);
    logic [3:0] nx;
    for (int k = 0; k < 4; k++) begin
      m_lock[k] = 1'b0;
      m_pd[k]   = 1'b0;
      if (l) begin
        m_cnt[k] = 0;
        if (s != 4'h0) begin
          m_q[k] = s; m_start[k] = s;
        end else begin
          m_q[k] = 4'h1; m_start[k] = 4'h1; m_lock[k] = 1'b1;
        end
      end else if (e) begin
        if (m_q[k] == 4'h0) begin
          m_q[k] = 4'h1; m_start[k] = 4'h1; m_cnt[k] = 0; m_lock[k] = 1'b1;
        end else begin
          nx = ref_next(k, m_q[k]);
          if (nx == m_start[k]) begin
            m_pd[k] = 1'b1; m_plen[k] = sat_inc(k, m_cnt[k]); m_cnt[k] = 0;
          end else begin
            m_cnt[k] = sat_inc(k, m_cnt[k]);
          end
          m_q[k] = nx;
        end
      end
    end
  endtask

  task automatic check_all(input string ph);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s.q%0d", ph, k),    {28'd0, dq[k]},    {28'd0, m_q[k]});
      check($sformatf("%s.bit%0d", ph, k),  {31'd0, dbit[k]},  {31'd0, m_q[k][3]});
      check($sformatf("%s.lock%0d", ph, k), {31'd0, dlock[k]}, {31'd0, m_lock[k]});
      check($sformatf("%s.pd%0d", ph, k),   {31'd0, dpd[k]},   {31'd0, m_pd[k]});
      check($sformatf("%s.plen%0d", ph, k), get_plen(k),       32'(m_plen[k]));
    end
  endtask

  task automatic tick(input logic l, input logic [3:0] s, input logic e, input string ph);
    load = l; seed_in = s; enable = e;
    @(posedge clk);
    #1;
    model_edge(l, s, e);
    check_all(ph);
  endtask

  initial begin
    int         n;
    int         guard;
    logic       e;
    logic [3:0] prev;

    reset = 1'b1; load = 1'b0; enable = 1'b0; seed_in = 4'h0;
    model_reset();
    #12 reset = 1'b0;
    check_all("rst");

    // Free run from reset: both forms walk their maximal sequence.
    for (int i = 0; i < 15; i++) begin
      tick(1'b0, 4'h0, 1'b1, "run");
      check("fib_seq", {28'd0, dq[0]}, {28'd0, fib_seq[i]});
      check("gal_seq", {28'd0, dq[1]}, {28'd0, gal_seq[i]});
    end
    check("fib_pd15", {31'd0, dpd[0]}, 32'd1);
    check("fib_len15", {16'd0, dplen[0]}, 32'd15);
    check("gal_pd15", {31'd0, dpd[1]}, 32'd1);
    check("gal_len15", {16'd0, dplen[1]}, 32'd15);

    // Load beats enable on the same edge; full period from the loaded seed.
    tick(1'b1, 4'hA, 1'b1, "ld");
    check("ld_q", {28'd0, dq[0]}, 32'h0A);
    tick(1'b0, 4'h0, 1'b1, "ld");
    check("ld_step1", {28'd0, dq[0]}, 32'h05);
    for (int i = 0; i < 13; i++) tick(1'b0, 4'h0, 1'b1, "ld");
    check("ld_pd_early", {31'd0, dpd[0]}, 32'd0);
    tick(1'b0, 4'h0, 1'b1, "ld");
    check("ld_pd", {31'd0, dpd[0]}, 32'd1);
    check("ld_len", {16'd0, dplen[0]}, 32'd15);
    check("ld_back", {28'd0, dq[0]}, 32'h0A);

    // Zero seed load recovers to SEED with a one-cycle lockup pulse.
    tick(1'b1, 4'h0, 1'b0, "ldz");
    check("ldz_q", {28'd0, dq[0]}, 32'h01);
    check("ldz_lock", {31'd0, dlock[0]}, 32'd1);
    tick(1'b0, 4'h0, 1'b0, "ldz");
    check("ldz_lock_end", {31'd0, dlock[0]}, 32'd0);
    check("ldz_hold", {28'd0, dq[0]}, 32'h01);

    // TAPS=0 shifts into the all-zero state; next enable must recover.
    for (int i = 0; i < 4; i++) tick(1'b0, 4'h0, 1'b1, "zero");
    check("zero_q0", {28'd0, dq[2]}, 32'h00);
    tick(1'b0, 4'h0, 1'b1, "zero");
    check("zero_rec_q", {28'd0, dq[2]}, 32'h01);
    check("zero_rec_lock", {31'd0, dlock[2]}, 32'd1);
    check("zero_rec_pd", {31'd0, dpd[2]}, 32'd0);

    // Random enable gaps during one period restarted from SEED.
    tick(1'b1, 4'h0, 1'b0, "gap");
    n = 0;
    guard = 0;
    while (n < 15 && guard < 300) begin
      e = 1'($urandom_range(0, 1));
      prev = dq[0];
      tick(1'b0, 4'h0, e, "gap");
      guard++;
      if (e) n++;
      else check("gap_hold", {28'd0, dq[0]}, {28'd0, prev});
    end
    check("gap_steps", 32'(n), 32'd15);
    check("gap_pd", {31'd0, dpd[0]}, 32'd1);
    check("gap_len", {16'd0, dplen[0]}, 32'd15);

    // Asynchronous reset between edges while period_done is high.
    #2 reset = 1'b1;
    #1;
    check("arst_q", {28'd0, dq[0]}, 32'h01);
    check("arst_len", {16'd0, dplen[0]}, 32'd0);
    check("arst_pd", {31'd0, dpd[0]}, 32'd0);
    check("arst_lock", {31'd0, dlock[0]}, 32'd0);
    model_reset();
    check_all("arst");
    #2 reset = 1'b0;
    tick(1'b0, 4'h0, 1'b1, "arst");
    check("arst_restart", {28'd0, dq[0]}, 32'h02);

    // Fixed point of the rotation: every enabled step completes a period.
    tick(1'b1, 4'hF, 1'b0, "fix");
    tick(1'b0, 4'h0, 1'b1, "fix");
    check("fix_pd", {31'd0, dpd[3]}, 32'd1);
    check("fix_len", {30'd0, plen_rot}, 32'd1);
    tick(1'b0, 4'h0, 1'b1, "fix");
    check("fix_pd2", {31'd0, dpd[3]}, 32'd1);

    // Random mix of loads (some zero), enables and holds.
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) != 0), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
